mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target for the multicycle CPU.
// Accepts a MemRead/MemWrite level in IDLE, waits WAIT_CYCLES, then answers
// with a one-cycle MemReady pulse. Malformed requests (misaligned address or
// both strobes high) still complete, flagged by a ReqErr pulse.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  output logic        MemReady,
  output logic        Busy,
  output logic        ReqErr
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_next;
  logic                    w_accept;

  // Latched request (only the address bits that matter are kept)
  logic                    r_rd;
  logic                    r_wr;
  logic [DEPTH_LOG2+1:0]   r_addr;
  logic [31:0]             r_wdata;

  // Storage array, deliberately not reset
  logic [31:0]             r_mem [DEPTH];

  // Request view used on the edge that enters RESPOND: live inputs when
  // coming straight from IDLE (WAIT_CYCLES = 0), latched copy otherwise
  logic                    w_eff_rd;
  logic                    w_eff_wr;
  logic [DEPTH_LOG2+1:0]   w_eff_addr;
  logic [DEPTH_LOG2-1:0]   w_eff_idx;
  logic [DEPTH_LOG2-1:0]   w_wr_idx;
  logic                    w_enter_respond;
  logic                    w_do_read;
  logic                    w_err;

  // Upper address bits alias away; fold them so they are visibly consumed
  logic                    w_unused_addr;
  assign w_unused_addr = ^Address[31:DEPTH_LOG2+2];

  // State and wait-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          w_accept   = 1'b1;
          w_cnt_next = LP_WAIT;
          if (LP_WAIT == 4'd0) begin
            w_next_state = S_RESPOND;
          end else begin
            w_next_state = S_WAIT;
          end
        end else begin
          w_cnt_next   = 4'd0;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        // <= guards against a stuck zero count
        if (r_cnt <= 4'd1) begin
          w_next_state = S_RESPOND;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESPOND: begin
        w_cnt_next   = 4'd0;
        w_next_state = S_IDLE;
      end
      default: begin
        w_cnt_next   = 4'd0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Effective request decode for the response edge
  always_comb begin
    w_eff_rd   = r_rd;
    w_eff_wr   = r_wr;
    w_eff_addr = r_addr;
    if (r_state == S_IDLE) begin
      w_eff_rd   = MemRead;
      w_eff_wr   = MemWrite;
      w_eff_addr = Address[DEPTH_LOG2+1:0];
    end else begin
      w_eff_rd   = r_rd;
      w_eff_wr   = r_wr;
      w_eff_addr = r_addr;
    end
    w_eff_idx       = w_eff_addr[DEPTH_LOG2+1:2];
    w_wr_idx        = r_addr[DEPTH_LOG2+1:2];
    w_enter_respond = (w_next_state == S_RESPOND) && (r_state != S_RESPOND);
    w_do_read       = w_eff_rd && !w_eff_wr;
    w_err           = (w_eff_rd && w_eff_wr) || (w_eff_addr[1:0] != 2'b00);
  end

  // Capture the request on the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_rd    <= MemRead;
      r_wr    <= MemWrite;
      r_addr  <= Address[DEPTH_LOG2+1:0];
      r_wdata <= WriteData;
    end else begin
      r_rd    <= r_rd;
      r_wr    <= r_wr;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
    end
  end

  // Registered outputs; read data is loaded on the edge entering RESPOND
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemData  <= 32'd0;
      MemReady <= 1'b0;
      Busy     <= 1'b0;
      ReqErr   <= 1'b0;
    end else begin
      MemReady <= w_enter_respond;
      ReqErr   <= w_enter_respond && w_err;
      Busy     <= (w_next_state != S_IDLE);
      if (w_enter_respond && w_do_read) begin
        MemData <= r_mem[w_eff_idx];
      end else begin
        MemData <= MemData;
      end
    end
  end

  // Array write commits on the edge leaving RESPOND; reset forces IDLE,
  // so an abandoned write never reaches this point
  always_ff @(posedge clk) begin
    if ((r_state == S_RESPOND) && r_wr && !r_rd) begin
      r_mem[w_wr_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with 2 wait states,
// one with none. A reference array model feeds per-instance scoreboards
// that are drained whenever MemReady is seen.
module tb_mem_responder;

  localparam int WA = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_data, b_data;
  logic        a_ready, a_busy, a_err, b_ready, b_busy, b_err;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  exp_t        e_a, e_b;
  logic [31:0] model [256];
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [31:0] vals [3];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WA)) u_dut_a (
    .clk(clk), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr),
    .Address(a_addr), .WriteData(a_wdata), .MemData(a_data),
    .MemReady(a_ready), .Busy(a_busy), .ReqErr(a_err)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr),
    .Address(b_addr), .WriteData(b_wdata), .MemData(b_data),
    .MemReady(b_ready), .Busy(b_busy), .ReqErr(b_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard drain for instance A
  always @(negedge clk) begin
    if (a_ready === 1'b1) begin
      if (sb_a.size() == 0) begin
        check_val("a_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e_a = sb_a.pop_front();
        check_val("a_memdata", a_data, e_a.data);
        check_val("a_reqerr", 32'(a_err), 32'(e_a.err));
      end
    end
  end

  // Scoreboard drain for instance B
  always @(negedge clk) begin
    if (b_ready === 1'b1) begin
      if (sb_b.size() == 0) begin
        check_val("b_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e_b = sb_b.pop_front();
        check_val("b_memdata", b_data, e_b.data);
        check_val("b_reqerr", 32'(b_err), 32'(e_b.err));
      end
    end
  end

  // One complete access on instance A with latency and Busy checks
  task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   idx;
    int   n;
    idx   = int'(addr[9:2]);
    e.err = (rd & wr) | (addr[1:0] != 2'b00);
    if (rd && !wr) begin
      last_a = model[idx];
    end
    e.data = last_a;
    sb_a.push_back(e);
    check_val("a_idle_before", 32'(a_busy), 32'd0);
    a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
    @(posedge clk); #1;
    a_rd = 1'b0; a_wr = 1'b0;
    check_val("a_busy_accept", 32'(a_busy), 32'd1);
    n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("a_latency", 32'(n), 32'(WA));
    check_val("a_busy_ready", 32'(a_busy), 32'd1);
    @(posedge clk); #1;
    check_val("a_ready_pulse", 32'(a_ready), 32'd0);
    check_val("a_busy_done", 32'(a_busy), 32'd0);
    if (wr && !rd) begin
      model[idx] = wdata;
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    last_a = 32'd0; last_b = 32'd0;
    vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0004; vals[2] = 32'h3333_0008;
    #12;
    check_val("rst_a_data", a_data, 32'd0);
    check_val("rst_a_ready", 32'(a_ready), 32'd0);
    check_val("rst_a_busy", 32'(a_busy), 32'd0);
    check_val("rst_a_err", 32'(a_err), 32'd0);
    check_val("rst_b_data", b_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero wait states, requests held high: three writes then three reads
    for (int i = 0; i < 6; i++) begin
      b_wr = (i < 3);
      b_rd = (i >= 3);
      b_addr = 32'(i % 3) * 32'd4;
      b_wdata = vals[i % 3];
      e.err = 1'b0;
      e.data = (i < 3) ? last_b : vals[i % 3];
      sb_b.push_back(e);
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (b_ready !== 1'b1 && n < 10);
      check_val("b_spacing", 32'(n), (i == 0) ? 32'd1 : 32'd2);
    end
    b_rd = 1'b0; b_wr = 1'b0;
    @(posedge clk); #1;
    check_val("b_busy_end", 32'(b_busy), 32'd0);

    // Write then read back with two wait states
    access_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access_a(1'b1, 1'b0, 32'h10, 32'd0);
    check_val("a_rd_deadbeef", a_data, 32'hDEADBEEF);

    // Misaligned read
    access_a(1'b0, 1'b1, 32'h10, 32'h12345678);
    access_a(1'b0, 1'b1, 32'h20, 32'h0000AAAA);
    access_a(1'b1, 1'b0, 32'h13, 32'd0);
    check_val("a_misaligned", a_data, 32'h12345678);

    // Both strobes high: no access, MemData held, ReqErr pulses
    access_a(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
    check_val("a_both_held", a_data, 32'h12345678);
    access_a(1'b1, 1'b0, 32'h20, 32'd0);
    check_val("a_both_nowrite", a_data, 32'h0000AAAA);

    // Reset during the WAIT of a write abandons it
    access_a(1'b0, 1'b1, 32'h30, 32'h11);
    a_wr = 1'b1; a_addr = 32'h30; a_wdata = 32'h55;
    @(posedge clk); #1;
    a_wr = 1'b0;
    check_val("a_busy_wait", 32'(a_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_data", a_data, 32'd0);
    check_val("arst_ready", 32'(a_ready), 32'd0);
    check_val("arst_busy", 32'(a_busy), 32'd0);
    check_val("arst_err", 32'(a_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_a = 32'd0;
    access_a(1'b1, 1'b0, 32'h30, 32'd0);
    check_val("a_abandoned_wr", a_data, 32'h11);

    // Address aliasing modulo 1 KiB
    access_a(1'b0, 1'b1, 32'h400, 32'h0000CAFE);
    access_a(1'b1, 1'b0, 32'h0, 32'd0);
    check_val("a_alias", a_data, 32'h0000CAFE);

    @(posedge clk); #1;
    check_val("a_sb_left", 32'(sb_a.size()), 32'd0);
    check_val("b_sb_left", 32'(sb_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
